// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed driver for common-anode 7-segment displays.
// Each frame scans NUM_DIGITS slots of TICK_DIV cycles, starting with digit 0.
// Each slot opens with a GUARD-cycle all-off interval so that no ghosting
// occurs when the enable moves to the next digit. The digit data and
// controls are copied into shadow registers once per frame, so a display
// never shows a half-updated value.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   i_hex          packed nibble per digit; digit 0 (rightmost) is in bits [3:0]
//   i_dot          per-digit decimal point enable
//   i_blank        per-digit force-dark control
//   i_blink        per-digit blink enable (dark during the off phase)
//   i_lz_blank     leading-zero suppression enable
//   fnd_com        active-low digit enables (at most one low)
//   fnd_data       active-low segments {dp,g,f,e,d,c,b,a}
//   o_frame_start  one-cycle pulse in the first cycle of each frame

// Per-digit segment encoder with darkness resolution.
module fnd_digit (
    input  logic [3:0] hex,
    input  logic       dot,
    input  logic       blank,
    input  logic       blink,
    input  logic       phase,
    input  logic       lz_kill,
    output logic [7:0] seg
);
    logic [7:0] raw;

    always_comb begin
        case (hex)
            4'h0: raw = 8'hC0;
            4'h1: raw = 8'hF9;
            4'h2: raw = 8'hA4;
            4'h3: raw = 8'hB0;
            4'h4: raw = 8'h99;
            4'h5: raw = 8'h92;
            4'h6: raw = 8'h82;
            4'h7: raw = 8'hF8;
            4'h8: raw = 8'h80;
            4'h9: raw = 8'h90;
            4'hA: raw = 8'h88;
            4'hB: raw = 8'h83;
            4'hC: raw = 8'hC6;
            4'hD: raw = 8'hA1;
            4'hE: raw = 8'h86;
            default: raw = 8'h8E;
        endcase
        if (dot) raw[7] = 1'b0;
        // Blank, blink and LZ suppression all produce the same dark result,
        // so their order of precedence makes no difference to the output.
        seg = (blank || (blink && phase) || lz_kill) ? 8'hFF : raw;
    end
endmodule

module fnd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 100_000,
    parameter int GUARD        = 2_000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] i_hex,
    input  logic [NUM_DIGITS-1:0]   i_dot,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    input  logic [NUM_DIGITS-1:0]   i_blink,
    input  logic                    i_lz_blank,
    output logic [NUM_DIGITS-1:0]   fnd_com,
    output logic [7:0]              fnd_data,
    output logic                    o_frame_start
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0] cnt, cnt_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [FW-1:0] fcnt, fcnt_nx;
    logic          phase, phase_nx;
    logic          slot_end, frame_end, guard_nx;

    logic [NUM_DIGITS-1:0][3:0] hex_q, hex_nx, hex_in;
    logic [NUM_DIGITS-1:0]      dot_q, dot_nx, blank_q, blank_nx, blink_q, blink_nx;
    logic                       lz_q, lz_nx;
    logic [NUM_DIGITS-1:0]      dz, zrun, lz_kill;
    logic [NUM_DIGITS-1:0][7:0] seg;
    logic [NUM_DIGITS-1:0]      com_nx;

    assign hex_in = i_hex;

    // The outputs are registered from the values that cnt/idx/shadow take on the
    // same clock edge, so they describe the current slot without any lag.
    always_comb begin
        slot_end  = (cnt == CNT_MAX);
        frame_end = slot_end && (idx == IDX_MAX);
        cnt_nx    = slot_end ? '0 : cnt + 1'b1;
        idx_nx    = idx;
        if (slot_end) idx_nx = (idx == IDX_MAX) ? '0 : idx + 1'b1;
        fcnt_nx  = fcnt;
        phase_nx = phase;
        if (frame_end) begin
            fcnt_nx = (fcnt == FRM_MAX) ? '0 : fcnt + 1'b1;
            if (fcnt == FRM_MAX) phase_nx = ~phase;
        end
        hex_nx   = frame_end ? hex_in     : hex_q;
        dot_nx   = frame_end ? i_dot      : dot_q;
        blank_nx = frame_end ? i_blank    : blank_q;
        blink_nx = frame_end ? i_blink    : blink_q;
        lz_nx    = frame_end ? i_lz_blank : lz_q;
        guard_nx = (cnt_nx < GUARD_C);
        for (int k = 0; k < NUM_DIGITS; k++)
            com_nx[k] = guard_nx || (idx_nx != IW'(k));
    end

    // Leading-zero run: zrun[k] is set when digit k and every digit above it
    // are zero with no dot. Digit 0 always stays visible.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        assign dz[k] = (hex_nx[k] == 4'h0) && !dot_nx[k];
        if (k == NUM_DIGITS - 1) begin : g_top
            assign zrun[k] = dz[k];
        end else begin : g_run
            assign zrun[k] = dz[k] && zrun[k+1];
        end
        if (k == 0) begin : g_d0
            assign lz_kill[k] = 1'b0;
        end else begin : g_dn
            assign lz_kill[k] = lz_nx && zrun[k];
        end
        fnd_digit u_dig (
            .hex    (hex_nx[k]),
            .dot    (dot_nx[k]),
            .blank  (blank_nx[k]),
            .blink  (blink_nx[k]),
            .phase  (phase_nx),
            .lz_kill(lz_kill[k]),
            .seg    (seg[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            idx           <= '0;
            fcnt          <= '0;
            phase         <= 1'b0;
            hex_q         <= '0;
            dot_q         <= '0;
            blank_q       <= '1;   // first frame after reset is dark
            blink_q       <= '0;
            lz_q          <= 1'b0;
            fnd_com       <= '1;
            fnd_data      <= 8'hFF;
            o_frame_start <= 1'b0;
        end else begin
            cnt           <= cnt_nx;
            idx           <= idx_nx;
            fcnt          <= fcnt_nx;
            phase         <= phase_nx;
            hex_q         <= hex_nx;
            dot_q         <= dot_nx;
            blank_q       <= blank_nx;
            blink_q       <= blink_nx;
            lz_q          <= lz_nx;
            fnd_com       <= com_nx;
            fnd_data      <= guard_nx ? 8'hFF : seg[idx_nx];
            o_frame_start <= frame_end;
        end
    end
endmodule
